// File: rtl/gpio_access_arbiter_if.sv
// Request/response and subunit register-port bundle for gpio_access_arbiter.
// Requester i raises req[i] (with its fields) and holds it until gnt[i]. That grant is the
// acceptance. done[i] then pulses once with rdata_out, and the strobes go out for exactly one cycle.
interface gpio_access_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata_out;
  logic                      busy;
  logic                      gpio_read;
  logic                      gpio_write;
  logic [ADDR_W-1:0]         gpio_addr;
  logic [DATA_W-1:0]         gpio_wdata;
  logic [DATA_W-1:0]         gpio_rdata;

  modport slave (
    input  req, req_write, req_addr, req_wdata, gpio_rdata,
    output gnt, done, rdata_out, busy, gpio_read, gpio_write, gpio_addr, gpio_wdata
  );

  modport master (
    output req, req_write, req_addr, req_wdata, gpio_rdata,
    input  gnt, done, rdata_out, busy, gpio_read, gpio_write, gpio_addr, gpio_wdata
  );
endinterface

// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing the GPIO lite register port among NUM_REQ requesters.
// Each access goes through IDLE -> ISSUE -> CAPTURE -> RESP. It issues a single one-cycle strobe, so read-to-clear fires once.
module gpio_access_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
) (
  input  logic                  pclk12,
  input  logic                  n_reset12,
  gpio_access_arbiter_if.slave  bus,
  output logic [1:0]            o_dbg_state
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_rr_last;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic                r_gpio_read;
  logic                r_gpio_write;
  logic [ADDR_W-1:0]   r_gpio_addr;
  logic [DATA_W-1:0]   r_gpio_wdata;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  int                  w_cand;

  // Search upward from the requester just after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = (int'(r_rr_last) + k) % NUM_REQ;
      if (!w_found && bus.req[IDX_W'(w_cand)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_cand);
      end
    end
  end

  always_ff @(posedge pclk12) begin
    if (!n_reset12) begin
      r_state      <= S_IDLE;
      r_rr_last    <= IDX_W'(NUM_REQ - 1);
      r_idx        <= '0;
      r_write      <= 1'b0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_rdata      <= '0;
      r_busy       <= 1'b0;
      r_gpio_read  <= 1'b0;
      r_gpio_write <= 1'b0;
      r_gpio_addr  <= '0;
      r_gpio_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_ISSUE;
            r_idx        <= w_win;
            r_rr_last    <= w_win;
            r_write      <= bus.req_write[w_win];
            r_gnt        <= ONE << w_win;
            r_busy       <= 1'b1;
            r_gpio_write <= bus.req_write[w_win];
            r_gpio_read  <= ~bus.req_write[w_win];
            r_gpio_addr  <= bus.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_gpio_wdata <= bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          r_state      <= S_CAPTURE;
          r_gnt        <= '0;
          r_gpio_read  <= 1'b0;
          r_gpio_write <= 1'b0;
          r_gpio_addr  <= '0;
          r_gpio_wdata <= '0;
        end
        S_CAPTURE: begin
          // The subunit registered its read data on the strobe edge, so it is valid now.
          r_rdata <= r_write ? '0 : bus.gpio_rdata;
          r_done  <= ONE << r_idx;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.rdata_out  = r_rdata;
  assign bus.busy       = r_busy;
  assign bus.gpio_read  = r_gpio_read;
  assign bus.gpio_write = r_gpio_write;
  assign bus.gpio_addr  = r_gpio_addr;
  assign bus.gpio_wdata = r_gpio_wdata;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Self-checking bench for gpio_access_arbiter. It includes a simple GPIO subunit environment
// and a round-robin reference model that keeps shadow register contents.
module tb_gpio_access_arbiter;
  localparam int NR = 2;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int INT_ADDR = 32;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  gpio_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();
  logic [1:0] dbg;

  gpio_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk12(clk), .n_reset12(n_rst), .bus(bus), .o_dbg_state(dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GPIO subunit environment: plain registers plus a read-to-clear interrupt status
  logic [DW-1:0] env_mem [64];
  logic [DW-1:0] env_int;
  logic [DW-1:0] env_rdata;
  logic [DW-1:0] pin_set = '0;
  logic          env_init = 1'b0;
  assign bus.gpio_rdata = env_rdata;

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= '0;
      env_int   <= '0;
      env_rdata <= '0;
    end else begin
      if (bus.gpio_write && int'(bus.gpio_addr) != INT_ADDR) env_mem[bus.gpio_addr] <= bus.gpio_wdata;
      if (bus.gpio_read) env_rdata <= (int'(bus.gpio_addr) == INT_ADDR) ? env_int : env_mem[bus.gpio_addr];
      env_int <= ((bus.gpio_read && int'(bus.gpio_addr) == INT_ADDR) ? '0 : env_int) | pin_set;
    end
  end

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] ref_int;
  int            m_last;
  logic [DW-1:0] exp_q[$];
  int            last_gnt_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int r, input logic wr, input int a, input int d);
    bus.req[r]                = 1'b1;
    bus.req_write[r]          = wr;
    bus.req_addr[r*AW +: AW]  = AW'(a);
    bus.req_wdata[r*DW +: DW] = DW'(d);
  endtask

  // Entered and left while the DUT sits in IDLE ahead of its latch edge.
  task automatic one_pass(input bit drop, output int w);
    logic [NR-1:0] mask, oh;
    logic          wr;
    int            a, d;
    logic [DW-1:0] exp_rd, got_rd;
    mask = bus.req;
    w = -1;
    for (int k = 1; k <= NR; k++)
      if (w < 0 && mask[(m_last + k) % NR]) w = (m_last + k) % NR;
    if (w < 0) begin
      n_cmp++; n_err++;
      $display("FAIL one_pass_no_req: req=%b required nonzero", mask);
      return;
    end
    wr = bus.req_write[w];
    a  = int'(bus.req_addr[w*AW +: AW]);
    d  = int'(bus.req_wdata[w*DW +: DW]);
    if (wr) begin
      if (a != INT_ADDR) ref_mem[a] = DW'(d);
      exp_rd = '0;
    end else if (a == INT_ADDR) begin
      exp_rd = ref_int;
      ref_int = '0;
    end else exp_rd = ref_mem[a];
    exp_q.push_back(exp_rd);
    m_last = w;
    oh = NR'(1) << w;

    tick();  // ISSUE
    last_gnt_cyc = cyc;
    n_cmp++;
    if (bus.gnt !== oh || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL issue_gnt: gnt=%b busy=%b required gnt=%b busy=1", bus.gnt, bus.busy, oh);
    end
    n_cmp++;
    if (bus.gpio_write !== wr || bus.gpio_read !== !wr || bus.gpio_addr !== AW'(a) || bus.gpio_wdata !== DW'(d)) begin
      n_err++;
      $display("FAIL issue_strobe: wr=%b rd=%b addr=%h wdata=%h required wr=%b rd=%b addr=%h wdata=%h",
               bus.gpio_write, bus.gpio_read, bus.gpio_addr, bus.gpio_wdata, wr, !wr, AW'(a), DW'(d));
    end
    if (drop) bus.req[w] = 1'b0;

    tick();  // CAPTURE
    n_cmp++;
    if (bus.gpio_write !== 1'b0 || bus.gpio_read !== 1'b0 || bus.gpio_addr !== '0 || bus.gpio_wdata !== '0
        || bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL capture_quiet: wr=%b rd=%b addr=%h wdata=%h gnt=%b done=%b busy=%b required strobes/gnt/done 0 busy 1",
               bus.gpio_write, bus.gpio_read, bus.gpio_addr, bus.gpio_wdata, bus.gnt, bus.done, bus.busy);
    end

    tick();  // RESP
    got_rd = exp_q.pop_front();
    n_cmp++;
    if (bus.done !== oh || bus.rdata_out !== got_rd) begin
      n_err++;
      $display("FAIL resp_done: done=%b rdata=%h required done=%b rdata=%h", bus.done, bus.rdata_out, oh, got_rd);
    end

    tick();  // back in IDLE
    n_cmp++;
    if (bus.done !== '0 || bus.busy !== 1'b0 || bus.rdata_out !== got_rd) begin
      n_err++;
      $display("FAIL idle_hold: done=%b busy=%b rdata=%h required done=0 busy=0 rdata=%h",
               bus.done, bus.busy, bus.rdata_out, got_rd);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({bus.gnt, bus.done, bus.rdata_out, bus.busy, bus.gpio_read, bus.gpio_write,
         bus.gpio_addr, bus.gpio_wdata, dbg} !== '0) begin
      n_err++;
      $display("FAIL %s: gnt=%b done=%b rdata=%h busy=%b rd=%b wr=%b addr=%h wdata=%h state=%0d required all 0",
               name, bus.gnt, bus.done, bus.rdata_out, bus.busy, bus.gpio_read, bus.gpio_write,
               bus.gpio_addr, bus.gpio_wdata, dbg);
    end
  endtask

  task automatic test_reset();
    int w;
    n_rst = 1'b0;
    env_init = 1'b1;
    drive_req(0, 1'b0, 0, 0);
    drive_req(1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero("reset_outputs");
    end
    env_init = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    ref_int = '0;
    m_last = NR - 1;
    n_rst = 1'b1;
    one_pass(1'b1, w);
    n_cmp++;
    if (w != 0) begin
      n_err++;
      $display("FAIL reset_first_grant: winner=%0d required 0", w);
    end
    bus.req = '0;
  endtask

  task automatic test_write();
    int w;
    drive_req(0, 1'b1, 8'h08, 16'h00FF);
    one_pass(1'b1, w);
  endtask

  task automatic test_read();
    int w;
    drive_req(1, 1'b1, 8'h04, 16'hA5A5);
    one_pass(1'b1, w);
    drive_req(1, 1'b0, 8'h04, 0);
    one_pass(1'b1, w);
  endtask

  task automatic test_back_to_back();
    int w, first, prev;
    drive_req(0, 1'b0, 8'h08, 0);
    drive_req(1, 1'b0, 8'h04, 0);
    prev = m_last;
    for (int k = 0; k < 4; k++) begin
      one_pass(1'b0, w);
      if (k == 0) first = last_gnt_cyc;
      n_cmp++;
      if (w == prev || last_gnt_cyc - first != 4 * k) begin
        n_err++;
        $display("FAIL back_to_back: pass=%0d winner=%0d prev=%0d gnt_offset=%0d required alternate, offset %0d",
                 k, w, prev, last_gnt_cyc - first, 4 * k);
      end
      prev = w;
    end
    bus.req = '0;
  endtask

  task automatic test_int_status();
    int w;
    pin_set = 16'h0008;
    tick();
    pin_set = '0;
    ref_int = ref_int | 16'h0008;
    drive_req(0, 1'b0, INT_ADDR, 0);
    one_pass(1'b1, w);
    drive_req(0, 1'b0, INT_ADDR, 0);
    one_pass(1'b1, w);
  endtask

  task automatic test_reset_mid();
    int w;
    drive_req(0, 1'b0, 8'h04, 0);
    tick();  // ISSUE
    bus.req = '0;
    tick();  // CAPTURE
    n_rst = 1'b0;
    tick();
    check_all_zero("reset_mid_edge");
    n_rst = 1'b1;
    m_last = NR - 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.done !== '0 || bus.gpio_read !== 1'b0 || bus.gpio_write !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet: done=%b rd=%b wr=%b required 0", bus.done, bus.gpio_read, bus.gpio_write);
      end
    end
    drive_req(1, 1'b1, 8'h10, 16'h1234);
    one_pass(1'b1, w);
    drive_req(0, 1'b0, 8'h10, 0);
    one_pass(1'b1, w);
  endtask

  task automatic test_random();
    bit pend [NR];
    int waits [NR];
    int w, any;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; waits[i] = 0; end
    for (int p = 0; p < 30; p++) begin
      any = 0;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          waits[i] = 0;
          drive_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 65535));
        end
        if (pend[i]) any = 1;
      end
      if (any == 0) begin
        w = $urandom_range(0, NR - 1);
        pend[w] = 1;
        waits[w] = 0;
        drive_req(w, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 65535));
      end
      one_pass(1'b1, w);
      if (w < 0) return;
      n_cmp++;
      if (waits[w] > NR - 1) begin
        n_err++;
        $display("FAIL starvation: req=%0d waited=%0d required <= %0d", w, waits[w], NR - 1);
      end
      pend[w] = 0;
      for (int i = 0; i < NR; i++) if (pend[i]) waits[i]++;
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_int_status();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
